// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the single-issue RISC-V core. Holds the program counter,
// issues one word request at a time to instruction memory, and presents each
// returned instruction with its PC to decode. A redirect from execute flushes
// the stage, including a response that is still in flight.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_valid    request to instruction memory (decoded from state only)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         word address of the request, bits [1:0] always zero
//   imem_rsp_valid    response data valid (in order, latency >= 1)
//   imem_rsp_data     instruction word
//   redirect_valid    execute requests a PC change
//   redirect_pc       new PC (bits [1:0] ignored)
//   out_valid         instruction available to decode
//   out_ready         decode accepts
//   out_instruction   fetched instruction (NOP after reset or flush)
//   out_pc            address of out_instruction
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        hold_q, hold_d;

   logic        req_fire;

   // Request side is a pure decode of registered state.
   assign imem_req_valid  = (state_q == S_REQ);
   assign imem_addr       = pc_q;
   assign req_fire        = imem_req_valid & imem_req_ready;

   // A held instruction is never handed over in a redirect cycle.
   assign out_valid       = hold_q & ~redirect_valid;
   assign out_instruction = instr_q;
   assign out_pc          = out_pc_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      out_pc_d = out_pc_q;
      hold_d   = hold_q;

      if (redirect_valid && state_q != S_IDLE) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         hold_d  = 1'b0;
         instr_d = NOP_INSTR;
         case (state_q)
            // Old address already accepted: its response must be dropped.
            S_REQ:   state_d = req_fire ? S_DRAIN : S_REQ;
            // Outstanding response either arrives now (dropped) or later.
            S_WAIT,
            S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (req_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  instr_d  = imem_rsp_data;
                  out_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  hold_d   = 1'b1;
                  state_d  = S_HOLD;
               end
            end
            S_DRAIN: begin
               if (imem_rsp_valid) state_d = S_REQ;
            end
            S_HOLD: begin
               if (out_ready) begin
                  hold_d  = 1'b0;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         out_pc_q <= 32'h0000_0000;
         hold_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         out_pc_q <= out_pc_d;
         hold_q   <= hold_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. Inputs change just after the falling
// edge; outputs are sampled on the falling edge (plus #1 where out_valid's
// combinational dependence on redirect_valid matters).
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;

   int n_cmp = 0;
   int n_err = 0;

   instruction_fetch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_pc          (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // In REQ: confirm the request and complete the handshake; ends in WAIT.
   task automatic do_req(input string tag, input logic [31:0] exp_addr);
      chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, 32'd1);
      chk({tag, ".addr"}, imem_addr, exp_addr);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
   endtask

   // In WAIT: deliver one response; ends in HOLD.
   task automatic do_rsp(input logic [31:0] data);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
   endtask

   // In HOLD: decode takes the instruction; ends in REQ.
   task automatic do_take(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ins);
      out_ready = 1'b1;
      #1;
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".out_pc"}, out_pc, exp_pc);
      chk({tag, ".out_instr"}, out_instruction, exp_ins);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, 32'd0);
      chk({tag, ".addr"}, imem_addr, 32'h0);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".out_instr"}, out_instruction, 32'h0000_0013);
      chk({tag, ".out_pc"}, out_pc, 32'h0);
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;

      // Reset state, then release; IDLE lasts one cycle.
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Two sequential fetches at memory latency 1.
      do_req("f0", 32'h0);
      do_rsp(32'h0050_0093);
      do_take("f0", 32'h0, 32'h0050_0093);
      do_req("f1", 32'h4);
      do_rsp(32'h00A0_0113);
      do_take("f1", 32'h4, 32'h00A0_0113);

      // Backpressure in HOLD for five cycles.
      do_req("bp", 32'h8);
      do_rsp(32'h1111_1111);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp.req_valid", {31'd0, imem_req_valid}, 32'd0);
         chk("bp.out_pc", out_pc, 32'h8);
         chk("bp.out_instr", out_instruction, 32'h1111_1111);
         @(negedge clk);
      end
      do_take("bp", 32'h8, 32'h1111_1111);
      chk("bp.after_valid", {31'd0, out_valid}, 32'd0);

      // Redirect in WAIT; late response is drained.
      do_req("rw", 32'hC);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("rw.drain_req", {31'd0, imem_req_valid}, 32'd0);
         chk("rw.drain_out", {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end
      do_rsp(32'hDEAD_BEEF);
      chk("rw.dropped_out", {31'd0, out_valid}, 32'd0);
      do_req("rw2", 32'h100);
      do_rsp(32'h0070_0193);
      do_take("rw2", 32'h100, 32'h0070_0193);

      // Redirect coinciding with a response in WAIT: straight back to REQ.
      do_req("rr", 32'h104);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
      @(negedge clk);
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      chk("rr.out_valid", {31'd0, out_valid}, 32'd0);
      do_req("rr2", 32'h200);
      do_rsp(32'h0030_0213);

      // Redirect in HOLD with out_ready high: no transfer, instruction flushed.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      out_ready      = 1'b1;
      #1;
      chk("rh.out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      chk("rh.out_instr", out_instruction, 32'h0000_0013);
      chk("rh.out_valid2", {31'd0, out_valid}, 32'd0);

      // Redirect in REQ without handshake, then wrap of the PC.
      chk("rq.addr_before", imem_addr, 32'h300);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      do_req("wr", 32'hFFFF_FFFC);
      do_rsp(32'h0040_0293);
      do_take("wr", 32'hFFFF_FFFC, 32'h0040_0293);

      // Redirect in REQ with handshake: old response must be drained.
      chk("rd.addr", imem_addr, 32'h0);
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      @(negedge clk);
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      chk("rd.drain_req", {31'd0, imem_req_valid}, 32'd0);
      do_rsp(32'hCAFE_F00D);
      chk("rd.dropped_out", {31'd0, out_valid}, 32'd0);
      do_req("rd2", 32'h400);

      // Asynchronous reset in WAIT, in-flight response after release ignored.
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("arst");
      @(negedge clk);
      rst_n          = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFEED_FACE;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst.out_instr", out_instruction, 32'h0000_0013);
      do_req("arst2", 32'h0);
      do_rsp(32'h0050_0093);
      do_take("arst2", 32'h0, 32'h0050_0093);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
